// File: rtl/inst_buffer_pkg.sv
// Shared types and default sizing for the fetch-to-issue instruction buffer.
// Defaults mirror INST_BUF_DEPTH / INST_BUF_ENQ_WIDTH / INST_BUF_DEQ_WIDTH.
package inst_buffer_pkg;

  localparam int INST_BUF_DEPTH     = 8;
  localparam int INST_BUF_ENQ_WIDTH = 2;
  localparam int INST_BUF_DEQ_WIDTH = 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } IF_ID_PACKET;

endpackage

// File: rtl/inst_buf_compact.sv
// Prefix popcount of fetch lane valids: per-lane slot offset and total.
// Shared by the storage write path and the same-cycle bypass path.
module inst_buf_compact #(
  parameter int WIDTH = 2,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]         valid,
  output logic [WIDTH-1:0][CW-1:0] offset,
  output logic [CW-1:0]            total
);

  logic [CW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int k = 0; k < WIDTH; k++) begin
      offset[k] = acc;
      acc       = acc + CW'(valid[k]);
    end
    total = acc;
  end

endmodule

// File: rtl/inst_buffer.sv
// Circular fetch-to-issue instruction buffer with wrap-bit pointers.
// Optional same-cycle enq->deq bypass when empty: `define INST_BUF_BYPASS_EN.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH     = INST_BUF_DEPTH,
  parameter int ENQ_WIDTH = INST_BUF_ENQ_WIDTH,
  parameter int DEQ_WIDTH = INST_BUF_DEQ_WIDTH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [ENQ_WIDTH-1:0]             enq_valid,
  input  IF_ID_PACKET [ENQ_WIDTH-1:0]      enq_packet,
  output logic                             enq_ready,
  output IF_ID_PACKET [DEQ_WIDTH-1:0]      deq_packet,
  output logic [DEQ_WIDTH-1:0]             deq_valid,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]   deq_count,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             empty,
  output logic                             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(ENQ_WIDTH + 1);

  IF_ID_PACKET mem_q [DEPTH];
  IF_ID_PACKET mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [PW-1:0] cnt, free, deq_req, deq_n, byp_n, wr_ptr;
  logic [PW-1:0] rd_ptr [DEQ_WIDTH];
  logic          enq_fire;
  logic [ENQ_WIDTH-1:0][CW-1:0] enq_off;
  logic [CW-1:0] enq_n;

  inst_buf_compact #(
    .WIDTH (ENQ_WIDTH),
    .CW    (CW)
  ) u_compact (
    .valid  (enq_valid),
    .offset (enq_off),
    .total  (enq_n)
  );

  assign cnt       = tail_q - head_q;
  assign free      = PW'(DEPTH) - cnt;
  assign enq_ready = free >= PW'(ENQ_WIDTH);
  assign enq_fire  = enq_ready & (|enq_valid);
  assign deq_req   = PW'(deq_count);
  assign deq_n     = (deq_req > cnt) ? cnt : deq_req;

`ifdef INST_BUF_BYPASS_EN
  logic          byp_on;
  logic [PW-1:0] byp_avail;

  assign byp_on    = (cnt == '0) & ~flush;
  assign byp_avail = (PW'(enq_n) > PW'(DEQ_WIDTH)) ? PW'(DEQ_WIDTH) : PW'(enq_n);
  assign byp_n     = (byp_on & enq_fire)
                   ? ((deq_req > byp_avail) ? byp_avail : deq_req)
                   : '0;
`else
  assign byp_n = '0;
`endif

  // Bypassed lanes are consumed directly; the rest compact into tail slots.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    wr_ptr = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      head_d = head_q + deq_n;
      if (enq_fire) begin
        for (int k = 0; k < ENQ_WIDTH; k++) begin
          if (enq_valid[k] && (PW'(enq_off[k]) >= byp_n)) begin
            wr_ptr = tail_q + PW'(enq_off[k]) - byp_n;
            mem_d[wr_ptr[AW-1:0]] = enq_packet[k];
          end
        end
        tail_d = tail_q + PW'(enq_n) - byp_n;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i].valid <= 1'b0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      mem_q  <= mem_d;
    end
  end

  always_comb begin
    deq_valid  = '0;
    deq_packet = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      rd_ptr[i]     = head_q + PW'(i);
      deq_valid[i]  = PW'(i) < cnt;
      deq_packet[i] = mem_q[rd_ptr[i][AW-1:0]];
      if (!deq_valid[i]) begin
        deq_packet[i].valid = 1'b0;
      end
    end
`ifdef INST_BUF_BYPASS_EN
    if (byp_on) begin
      for (int i = 0; i < DEQ_WIDTH; i++) begin
        deq_valid[i]  = 1'b0;
        deq_packet[i] = '0;
        for (int k = 0; k < ENQ_WIDTH; k++) begin
          if (enq_valid[k] && (int'(enq_off[k]) == i)) begin
            deq_valid[i]  = 1'b1;
            deq_packet[i] = enq_packet[k];
          end
        end
      end
    end
`endif
  end

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (tail_q[AW-1:0] == head_q[AW-1:0]) &&
                 (tail_q[AW] != head_q[AW]);

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: stimulus pushes expected packets,
// a negedge monitor pops and compares whatever issue consumes.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   flush;
  logic [1:0]             enq_valid;
  IF_ID_PACKET [1:0]      enq_packet;
  logic                   enq_ready;
  IF_ID_PACKET [0:0]      deq_packet;
  logic [0:0]             deq_valid;
  logic [0:0]             deq_count;
  logic [3:0]             count;
  logic                   empty;
  logic                   full;

  int checks   = 0;
  int failures = 0;
  int mcount   = 0;
  IF_ID_PACKET exp_q[$];

  always #5 clock = ~clock;

  inst_buffer dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .enq_valid  (enq_valid),
    .enq_packet (enq_packet),
    .enq_ready  (enq_ready),
    .deq_packet (deq_packet),
    .deq_valid  (deq_valid),
    .deq_count  (deq_count),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  function automatic IF_ID_PACKET mk(input int n);
    IF_ID_PACKET p;
    p.inst  = 32'h1300_0000 | n;
    p.pc    = 32'h1000 + n * 4;
    p.npc   = p.pc + 4;
    p.valid = 1'b1;
    return p;
  endfunction

  function automatic void chk(input string nm, input logic [127:0] act,
                              input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  task automatic chk_state(input string nm);
    chk({nm, "_count"}, 128'(count), 128'(mcount));
    chk({nm, "_empty"}, 128'(empty), 128'(mcount == 0));
    chk({nm, "_full"}, 128'(full), 128'(mcount == 8));
    chk({nm, "_ready"}, 128'(enq_ready), 128'(mcount <= 6));
    chk({nm, "_dvalid"}, 128'(deq_valid), 128'(mcount > 0));
    if (mcount == 0)
      chk({nm, "_pktv"}, 128'(deq_packet[0].valid), 128'(0));
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && deq_valid[0] && deq_count != 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=%0h expected=none", deq_packet[0]);
      end else begin
        chk("sb_pkt", 128'(deq_packet[0]), 128'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input logic [1:0] v, input int a, input int b,
                      input logic dc, input logic fl);
    int  pc;
    int  byp;
    int  dn;
    bit  acc;
    enq_valid     = v;
    enq_packet[0] = mk(a);
    enq_packet[1] = mk(b);
    deq_count     = dc;
    flush         = fl;
    pc  = int'(v[0]) + int'(v[1]);
    acc = (8 - mcount) >= 2;
    dn  = (dc && mcount > 0) ? 1 : 0;
    byp = 0;
`ifdef INST_BUF_BYPASS_EN
    if (mcount == 0 && !fl && dc && pc > 0) byp = 1;
`endif
    if (fl) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      if (acc && pc > 0) begin
        if (v[0]) exp_q.push_back(mk(a));
        if (v[1]) exp_q.push_back(mk(b));
        mcount += pc - byp;
      end
      mcount -= dn;
    end
    @(negedge clock);
    @(posedge clock);
    #1;
    enq_valid = '0;
    deq_count = '0;
    flush     = 1'b0;
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    flush      = 1'b0;
    enq_valid  = '0;
    enq_packet = '0;
    deq_count  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_state("reset");
    reset = 1'b1;

    step(2'b11, 1, 2, 1'b0, 1'b0);
    chk_state("enq2");
    chk("head_a", 128'(deq_packet[0]), 128'(mk(1)));

    step(2'b11, 3, 4, 1'b0, 1'b0);
    step(2'b11, 5, 6, 1'b0, 1'b0);
    step(2'b11, 7, 8, 1'b0, 1'b0);
    chk_state("fill");
    step(2'b11, 90, 91, 1'b0, 1'b0);
    chk_state("full_hold");

    for (int i = 0; i < 8; i++) step(2'b00, 0, 0, 1'b1, 1'b0);
    chk_state("drained");
    step(2'b00, 0, 0, 1'b1, 1'b0);
    chk_state("clamp");

    for (int i = 0; i < 3; i++) step(2'b11, 10 + 2 * i, 11 + 2 * i, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(2'b00, 0, 0, 1'b1, 1'b0);
    chk_state("ptr6");

    step(2'b11, 20, 21, 1'b0, 1'b0);
    step(2'b11, 22, 23, 1'b0, 1'b0);
    chk_state("wrap_fill");
    chk("wrap_head", 128'(deq_packet[0]), 128'(mk(20)));
    for (int i = 0; i < 4; i++) step(2'b00, 0, 0, 1'b1, 1'b0);
    chk_state("wrap_done");

    step(2'b11, 30, 31, 1'b0, 1'b0);
    step(2'b11, 32, 33, 1'b1, 1'b0);
    chk_state("enq_deq");
    step(2'b10, 99, 40, 1'b0, 1'b0);
    chk_state("gap");
    for (int i = 0; i < 4; i++) step(2'b00, 0, 0, 1'b1, 1'b0);
    chk_state("gap_done");

    step(2'b11, 50, 51, 1'b0, 1'b0);
    step(2'b10, 98, 52, 1'b0, 1'b0);
    chk_state("pre_flush");
    step(2'b11, 60, 61, 1'b0, 1'b1);
    chk_state("flush");
    step(2'b11, 70, 71, 1'b0, 1'b0);
    chk("post_flush_head", 128'(deq_packet[0]), 128'(mk(70)));
    for (int i = 0; i < 2; i++) step(2'b00, 0, 0, 1'b1, 1'b0);
    chk_state("post_flush_done");

    step(2'b01, 80, 97, 1'b1, 1'b0);
    chk_state("bypass1");
    step(2'b11, 81, 82, 1'b1, 1'b0);
    chk_state("bypass2");
    for (int i = 0; i < 10 && mcount > 0; i++) step(2'b00, 0, 0, 1'b1, 1'b0);
    chk_state("bypass_done");

    step(2'b11, 95, 96, 1'b0, 1'b0);
    reset = 1'b0;
    flush = 1'b1;
    @(posedge clock);
    #1;
    reset  = 1'b1;
    flush  = 1'b0;
    mcount = 0;
    exp_q.delete();
    #1;
    chk_state("rst_over_flush");

    step(2'b11, 100, 101, 1'b0, 1'b0);
    step(2'b00, 0, 0, 1'b1, 1'b0);
    step(2'b00, 0, 0, 1'b1, 1'b0);
    chk_state("final");
    chk("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
